// File: rtl/kgp_mem_pkg.sv
// kgp_mem_pkg: shared memory-stage widths and mem_access_unit FSM encoding
package kgp_mem_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;
endpackage

// File: rtl/mem_addr_check.sv
// mem_addr_check: effective address (base+offset) -> word address, misaligned, out_of_range
module mem_addr_check
  import kgp_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [31:0]       base,
  input  logic [31:0]       offset,
  output logic [ADDR_W-1:0] waddr,
  output logic              misaligned,
  output logic              out_of_range
);
  logic [31:0] ea;
  assign ea           = base + offset;
  assign waddr        = ea[ADDR_W+1:2];
  assign misaligned   = |ea[1:0];
  assign out_of_range = |ea[31:ADDR_W+2];
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store controller; ports req_* (execute handshake), resp_* (writeback handshake), mem_* (data memory), err_count (saturating fault count)
module mem_access_unit
  import kgp_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_store,
  input  logic [31:0]         req_base,
  input  logic [31:0]         req_offset,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_write,
  output logic                mem_read,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [ERRCNT_W-1:0] err_count
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] waddr;
  logic misaligned, out_of_range, fault, accept;
  mem_addr_check #(.ADDR_W(ADDR_W)) u_chk (
    .base(req_base),
    .offset(req_offset),
    .waddr(waddr),
    .misaligned(misaligned),
    .out_of_range(out_of_range)
  );
  assign fault      = misaligned | out_of_range;
  assign accept     = (state == S_IDLE) && req_valid;
  assign req_ready  = state == S_IDLE;
  assign resp_valid = state == S_RESP;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    state_nx = !req_valid ? S_IDLE : fault ? S_RESP : S_ISSUE;
      S_ISSUE:   state_nx = mem_write ? S_RESP : S_CAPTURE;
      S_CAPTURE: state_nx = S_RESP;
      S_RESP:    state_nx = resp_ready ? S_IDLE : S_RESP;
      default:   state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      resp_data <= '0;
      resp_err  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      if (accept && fault) begin
        resp_err  <= 1'b1;
        resp_data <= '0;
        err_count <= &err_count ? err_count : err_count + 1'b1;
      end else if (accept) begin
        mem_addr  <= waddr;
        mem_wdata <= req_wdata;
        mem_write <= req_is_store;
        mem_read  <= !req_is_store;
      end else if (state == S_ISSUE) begin
        mem_write <= 1'b0;
        mem_read  <= 1'b0;
        resp_data <= '0;
        resp_err  <= 1'b0;
      end else if (state == S_CAPTURE) begin
        resp_data <= mem_rdata;
        resp_err  <= 1'b0;
      end else if (state == S_RESP && resp_ready) begin
        resp_data <= '0;
        resp_err  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized transaction-level reference checks of mem_access_unit
module tb_mem_access_unit;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int EW = 8;
  logic clk = 0, reset_n = 0, req_valid = 0, req_is_store = 0, resp_ready = 0;
  logic [31:0] req_base = 0, req_offset = 0;
  logic [DW-1:0] req_wdata = 0;
  logic req_ready, resp_valid, resp_err, mem_write, mem_read;
  logic [DW-1:0] resp_data, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic [EW-1:0] err_count;
  always #5 clk = ~clk;
  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .ERRCNT_W(EW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .err_count(err_count)
  );
  logic [DW-1:0] dmem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_write) dmem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_read ? dmem[mem_addr] : '0;
  end
  logic [31:0] ref_mem [int];
  int ref_err;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wd;
  logic e_rr, e_rv, e_re, e_mw, e_mr;
  logic [DW-1:0] e_rd, e_mwd;
  logic [AW-1:0] e_ma;
  logic [EW-1:0] e_ec;
  int checks = 0, passed = 0;
  bit chk_en = 0;
  int cur_k = 0, lat_seen = 0, wr_cyc = 0, rd_cyc = 0;
  logic [DW-1:0] data_seen = '0;
  logic [AW-1:0] strobe_addr = '0;
  bit prev_rv = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("req_ready", req_ready, e_rr);
    chk("resp_valid", resp_valid, e_rv);
    chk("resp_data", resp_data, e_rd);
    chk("resp_err", resp_err, e_re);
    chk("mem_write", mem_write, e_mw);
    chk("mem_read", mem_read, e_mr);
    chk("mem_addr", mem_addr, e_ma);
    chk("mem_wdata", mem_wdata, e_mwd);
    chk("err_count", err_count, e_ec);
    if (mem_write) wr_cyc++;
    if (mem_read) rd_cyc++;
    if (mem_write || mem_read) strobe_addr = mem_addr;
    if (resp_valid && !prev_rv) begin
      lat_seen = cur_k;
      data_seen = resp_data;
    end
    prev_rv = resp_valid;
  end
  function automatic void model(input logic [31:0] b, input logic [31:0] o, output bit f, output int wa);
    logic [31:0] ea;
    ea = b + o;
    f = (ea % 4 != 0) || (ea >= 32'(4 << AW));
    wa = int'(ea / 4);
  endfunction
  task automatic set_idle();
    e_rr = 1; e_rv = 0; e_rd = '0; e_re = 0; e_mw = 0; e_mr = 0;
    e_ma = hold_addr; e_mwd = hold_wd; e_ec = EW'(ref_err);
  endtask
  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 0;
      resp_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
  endtask
  task automatic do_req(input bit st, input logic [31:0] b, input logic [31:0] o,
                        input logic [DW-1:0] wd, input int hold, input int rst_at);
    bit f;
    int wa, lat, kend;
    logic [DW-1:0] rdv;
    @(negedge clk);
    req_valid = 1; req_is_store = st; req_base = b; req_offset = o; req_wdata = wd; resp_ready = 0;
    @(posedge clk);
    model(b, o, f, wa);
    lat = f ? 1 : st ? 2 : 3;
    kend = lat + hold;
    rdv = (!f && !st && ref_mem.exists(wa)) ? ref_mem[wa] : '0;
    if (f) ref_err = (ref_err == (1 << EW) - 1) ? ref_err : ref_err + 1;
    else begin
      hold_addr = wa[AW-1:0];
      hold_wd = wd;
      if (st) ref_mem[wa] = wd;
    end
    for (int k = 1; k <= kend; k++) begin
      cur_k = k;
      e_rr = 0; e_rv = k >= lat; e_rd = (k >= lat) ? rdv : '0; e_re = (k >= lat) && f;
      e_mw = !f && st && k == 1; e_mr = !f && !st && k == 1;
      e_ma = hold_addr; e_mwd = hold_wd; e_ec = EW'(ref_err);
      @(negedge clk);
      if (k == rst_at) begin
        reset_n = 0; req_valid = 0; resp_ready = 0;
        @(posedge clk);
        cur_k = 0; ref_err = 0; hold_addr = '0; hold_wd = '0;
        set_idle();
        @(negedge clk);
        reset_n = 1;
        return;
      end
      req_valid = 1'($urandom_range(0, 1));
      req_is_store = 1'($urandom_range(0, 1));
      req_base = $urandom_range(0, 8191);
      req_offset = $urandom;
      resp_ready = (k >= lat) ? (k == kend) : 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    cur_k = 0;
    set_idle();
  endtask
  initial begin
    bit f;
    int wa, w0, r0;
    ref_err = 0; hold_addr = '0; hold_wd = '0;
    for (int i = 0; i < (1 << AW); i++) dmem[i] = '0;
    set_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_err_count", err_count, 0);
    reset_n = 1;
    model(32'h40, 32'h4, f, wa);
    chk("model_wa", wa, 'h11);
    model(32'h41, 32'h0, f, wa);
    chk("model_misaligned", f, 1);
    w0 = wr_cyc; r0 = rd_cyc;
    do_req(1, 32'h40, 32'h4, 32'hDEADBEEF, 0, 0);
    chk("st_wr_cycles", wr_cyc - w0, 1);
    chk("st_addr", strobe_addr, 'h011);
    chk("st_latency", lat_seen, 2);
    do_req(0, 32'h40, 32'h4, $urandom, 0, 0);
    chk("ld_latency", lat_seen, 3);
    chk("ld_data", data_seen, 32'hDEADBEEF);
    chk("ld_rd_cycles", rd_cyc - r0, 1);
    do_req(1, 32'hFC, 32'h0, 32'h12345678, 0, 0);
    do_req(0, 32'h100, 32'hFFFFFFFC, 0, 0, 0);
    chk("neg_addr", strobe_addr, 'h03F);
    chk("neg_data", data_seen, 32'h12345678);
    do_req(1, 32'hFFC, 32'h0, 32'hA5A5_0001, 0, 0);
    chk("top_addr", strobe_addr, 'h3FF);
    do_req(0, 32'hFFFFFFFC, 32'h8, 0, 0, 0);
    chk("wrap_addr", strobe_addr, 'h001);
    w0 = wr_cyc; r0 = rd_cyc;
    do_req(0, 32'h41, 32'h0, 0, 0, 0);
    chk("mis_latency", lat_seen, 1);
    chk("mis_err_count", err_count, 1);
    do_req(0, 32'hFF8, 32'h8, 0, 0, 0);
    chk("edge_oor_latency", lat_seen, 1);
    for (int i = 0; i < 260; i++) do_req(1'($urandom_range(0, 1)), 32'h1000, 32'h0, $urandom, 0, 0);
    chk("sat_err_count", err_count, 8'hFF);
    chk("fault_no_strobe", (wr_cyc - w0) + (rd_cyc - r0), 0);
    r0 = rd_cyc;
    do_req(0, 32'h40, 32'h4, 0, 5, 0);
    chk("bp_data", data_seen, 32'hDEADBEEF);
    chk("bp_rd_cycles", rd_cyc - r0, 1);
    do_req(0, 32'h40, 32'h4, 0, 0, 2);
    do_idle(4);
    chk("rst_mid_err_count", err_count, 0);
    chk("rst_mid_no_resp", resp_valid, 0);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] b, o;
      b = 32'($urandom_range(0, 1100)) * 4 + (($urandom_range(0, 9) == 0) ? 32'd1 : 32'd0);
      o = 32'($urandom_range(0, 16)) * 4 - 32'd32;
      do_req(1'($urandom_range(0, 1)), b, o, $urandom, $urandom_range(0, 3), 0);
      if ($urandom_range(0, 4) == 0) do_idle($urandom_range(1, 3));
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
